// File: rtl/timx_pkg.sv
// rtl/timx_pkg.sv - shared register map, state encoding and step table for the timer config sequencer
package timx_pkg;

   localparam logic [15:0] REG_CR1   = 16'h0000;
   localparam logic [15:0] REG_DIER  = 16'h000C;
   localparam logic [15:0] REG_EGR   = 16'h0014;
   localparam logic [15:0] REG_CCMR1 = 16'h0018;
   localparam logic [15:0] REG_CCER  = 16'h0020;
   localparam logic [15:0] REG_ARR   = 16'h002C;
   localparam logic [15:0] REG_CCR1  = 16'h0034;
   localparam logic [15:0] REG_BDTR  = 16'h0044;

   localparam int          BDTR_MOE      = 15;
   localparam logic [15:0] BDTR_MOE_MASK = 16'(1 << BDTR_MOE);
   localparam logic [3:0]  LAST_STEP     = 4'd8;
   localparam logic [15:0] EGR_UG        = 16'h0001;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS,
      ST_RUN,
      ST_HOLDOFF,
      ST_ERR
   } state_t;

   function automatic logic [15:0] step_addr(input logic [3:0] step);
      case (step)
         4'd0:    return REG_ARR;
         4'd1:    return REG_CCR1;
         4'd2:    return REG_DIER;
         4'd3:    return REG_CCMR1;
         4'd4:    return REG_EGR;
         4'd5:    return REG_CCER;
         4'd6:    return REG_BDTR;
         4'd7:    return REG_CR1;
         4'd8:    return REG_BDTR;
         default: return REG_CR1;
      endcase
   endfunction

endpackage

// File: rtl/timx_apb_master.sv
// rtl/timx_apb_master.sv - single APB SETUP/ACCESS transfer engine with bounded wait on pready
module timx_apb_master
   import timx_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        req_write,
   input  logic [15:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        psel,
   output logic        penable,
   output logic        pwrite,
   output logic [15:0] paddr,
   output logic [31:0] pwdata,
   input  logic        pready,
   input  logic [31:0] prdata,
   output logic        xfer_done,
   output logic        xfer_err,
   output logic [31:0] rdata
);

   localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

   logic [15:0] wait_cnt;
   logic        in_access;

   assign in_access = psel && penable;
   assign xfer_done = in_access && pready;
   assign xfer_err  = in_access && !pready && (wait_cnt == WAIT_LAST);
   assign rdata     = prdata;

   // A request seen on the completing ACCESS edge starts the next SETUP directly,
   // so back-to-back transfers have no idle cycle between them.
   always_ff @(posedge clk) begin
      if (rst) begin
         psel     <= 1'b0;
         penable  <= 1'b0;
         pwrite   <= 1'b0;
         paddr    <= 16'h0;
         pwdata   <= 32'h0;
         wait_cnt <= 16'h0;
      end else if (!psel || xfer_done) begin
         wait_cnt <= 16'h0;
         if (req) begin
            psel    <= 1'b1;
            penable <= 1'b0;
            pwrite  <= req_write;
            paddr   <= req_addr;
            pwdata  <= req_wdata;
         end else begin
            psel    <= 1'b0;
            penable <= 1'b0;
         end
      end else if (!penable) begin
         penable <= 1'b1;
      end else if (xfer_err) begin
         psel     <= 1'b0;
         penable  <= 1'b0;
         wait_cnt <= 16'h0;
      end else begin
         wait_cnt <= wait_cnt + 16'h1;
      end
   end

endmodule

// File: rtl/timx_cfg_sequencer.sv
// rtl/timx_cfg_sequencer.sv - programs the timer into complementary PWM, verifies BDTR, re-arms MOE after break
module timx_cfg_sequencer
   import timx_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic        apb_clk,
   input  logic        apb_rst,
   input  logic        start,
   input  logic [15:0] cfg_arr,
   input  logic [15:0] cfg_ccr1,
   input  logic [15:0] cfg_dier,
   input  logic [15:0] cfg_ccmr1,
   input  logic [15:0] cfg_ccer,
   input  logic [15:0] cfg_bdtr,
   input  logic [15:0] cfg_cr1,
   input  logic        rearm_en,
   input  logic [15:0] rearm_delay,
   input  logic        timx_int_bk,
   output logic        timx_psel,
   output logic        timx_penable,
   output logic        timx_pwrite,
   output logic [15:0] timx_paddr,
   output logic [31:0] timx_pwdata,
   input  logic [31:0] timx_prdata,
   input  logic        timx_pready,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [7:0]  rearm_cnt
);

   state_t      state;
   logic [3:0]  step;
   logic [3:0]  step_n;
   logic [15:0] ccr1_q, dier_q, ccmr1_q, ccer_q, bdtr_q, cr1_q;
   logic [15:0] hold_cnt;
   logic        rearm_xfer;
   logic        bk_q;
   logic        accept;
   logic        bk_edge;
   logic        verify_ok;
   logic        req, req_write;
   logic [15:0] req_addr;
   logic [31:0] req_wdata;
   logic [15:0] step_data;
   logic        xfer_done, xfer_err;
   logic [31:0] rdata;

   assign accept    = start && (state == ST_IDLE || state == ST_RUN || state == ST_ERR);
   assign bk_edge   = timx_int_bk && !bk_q;
   assign step_n    = step + 4'd1;
   assign verify_ok = (rdata & {16'h0, ~BDTR_MOE_MASK}) == {16'h0, bdtr_q & ~BDTR_MOE_MASK};

   always_comb begin
      step_data = 16'h0;
      case (step_n)
         4'd1:    step_data = ccr1_q;
         4'd2:    step_data = dier_q;
         4'd3:    step_data = ccmr1_q;
         4'd4:    step_data = EGR_UG;
         4'd5:    step_data = ccer_q;
         4'd6:    step_data = bdtr_q;
         4'd7:    step_data = cr1_q;
         default: step_data = 16'h0;
      endcase
   end

   // Step 0 uses the live ARR input: it is the value being sampled on the accept edge.
   always_comb begin
      req       = 1'b0;
      req_write = 1'b1;
      req_addr  = REG_ARR;
      req_wdata = {16'h0, cfg_arr};
      if (accept) begin
         req = 1'b1;
      end else if (state == ST_ACCESS && xfer_done && !rearm_xfer && step != LAST_STEP) begin
         req       = 1'b1;
         req_write = (step_n != LAST_STEP);
         req_addr  = step_addr(step_n);
         req_wdata = {16'h0, step_data};
      end else if (state == ST_HOLDOFF && hold_cnt == 16'h0) begin
         req       = 1'b1;
         req_addr  = REG_BDTR;
         req_wdata = {16'h0, bdtr_q | BDTR_MOE_MASK};
      end
   end

   timx_apb_master #(.TIMEOUT(TIMEOUT)) u_apb (
      .clk       (apb_clk),
      .rst       (apb_rst),
      .req       (req),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .psel      (timx_psel),
      .penable   (timx_penable),
      .pwrite    (timx_pwrite),
      .paddr     (timx_paddr),
      .pwdata    (timx_pwdata),
      .pready    (timx_pready),
      .prdata    (timx_prdata),
      .xfer_done (xfer_done),
      .xfer_err  (xfer_err),
      .rdata     (rdata)
   );

   always_ff @(posedge apb_clk) begin
      if (apb_rst) begin
         state      <= ST_IDLE;
         step       <= 4'd0;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         rearm_cnt  <= 8'h0;
         rearm_xfer <= 1'b0;
         hold_cnt   <= 16'h0;
         bk_q       <= 1'b0;
         ccr1_q     <= 16'h0;
         dier_q     <= 16'h0;
         ccmr1_q    <= 16'h0;
         ccer_q     <= 16'h0;
         bdtr_q     <= 16'h0;
         cr1_q      <= 16'h0;
      end else begin
         bk_q <= timx_int_bk;
         done <= 1'b0;
         case (state)
            ST_IDLE, ST_RUN, ST_ERR: begin
               if (accept) begin
                  ccr1_q     <= cfg_ccr1;
                  dier_q     <= cfg_dier;
                  ccmr1_q    <= cfg_ccmr1;
                  ccer_q     <= cfg_ccer;
                  bdtr_q     <= cfg_bdtr;
                  cr1_q      <= cfg_cr1;
                  step       <= 4'd0;
                  rearm_xfer <= 1'b0;
                  error      <= 1'b0;
                  rearm_cnt  <= 8'h0;
                  busy       <= 1'b1;
                  state      <= ST_SETUP;
               end else if (state == ST_RUN && bk_edge && rearm_en) begin
                  hold_cnt <= rearm_delay;
                  busy     <= 1'b1;
                  state    <= ST_HOLDOFF;
               end
            end
            ST_SETUP: state <= ST_ACCESS;
            ST_ACCESS: begin
               if (xfer_err) begin
                  error <= 1'b1;
                  busy  <= 1'b0;
                  state <= ST_ERR;
               end else if (xfer_done) begin
                  if (rearm_xfer) begin
                     rearm_xfer <= 1'b0;
                     if (rearm_cnt != 8'hFF) rearm_cnt <= rearm_cnt + 8'h1;
                     busy  <= 1'b0;
                     state <= ST_RUN;
                  end else if (step == LAST_STEP) begin
                     busy <= 1'b0;
                     if (verify_ok) begin
                        done  <= 1'b1;
                        state <= ST_RUN;
                     end else begin
                        error <= 1'b1;
                        state <= ST_ERR;
                     end
                  end else begin
                     step  <= step_n;
                     state <= ST_SETUP;
                  end
               end
            end
            // The re-arm request is raised on the cycle the counter reads zero.
            ST_HOLDOFF: begin
               if (hold_cnt == 16'h0) begin
                  rearm_xfer <= 1'b1;
                  state      <= ST_SETUP;
               end else begin
                  hold_cnt <= hold_cnt - 16'h1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_timx_cfg_sequencer.sv
// tb/tb_timx_cfg_sequencer.sv - directed scoreboard bench for timx_cfg_sequencer against a small APB slave model
module tb_timx_cfg_sequencer;

   typedef struct {
      logic [15:0] addr;
      logic        write;
      logic [31:0] data;
   } xfer_t;

   logic        clk = 1'b0;
   logic        apb_rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] cfg_arr = 16'h0, cfg_ccr1 = 16'h0, cfg_dier = 16'h0, cfg_ccmr1 = 16'h0;
   logic [15:0] cfg_ccer = 16'h0, cfg_bdtr = 16'h0, cfg_cr1 = 16'h0;
   logic        rearm_en = 1'b0;
   logic [15:0] rearm_delay = 16'h0;
   logic        timx_int_bk = 1'b0;
   logic        timx_psel, timx_penable, timx_pwrite;
   logic [15:0] timx_paddr;
   logic [31:0] timx_pwdata;
   logic [31:0] timx_prdata = 32'h0;
   logic        timx_pready = 1'b0;
   logic        busy, done, error;
   logic [7:0]  rearm_cnt;

   xfer_t       exp_q[$];
   xfer_t       slv_e;
   logic [31:0] regs[64];
   logic        slv_rdy;
   int          n_cmp = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          t0 = 0;
   logic [15:0] ws_addr = 16'hFFFF;
   logic [15:0] stall_addr = 16'hFFFF;
   int          ws_n = 0;
   int          acc_cnt = 0;
   logic        ov_en = 1'b0;
   logic [31:0] ov_val = 32'h0;

   int          dc, rise, npsel;
   logic        dn, er, b1, bz;

   timx_cfg_sequencer #(.TIMEOUT(16)) dut (
      .apb_clk      (clk),
      .apb_rst      (apb_rst),
      .start        (start),
      .cfg_arr      (cfg_arr),
      .cfg_ccr1     (cfg_ccr1),
      .cfg_dier     (cfg_dier),
      .cfg_ccmr1    (cfg_ccmr1),
      .cfg_ccer     (cfg_ccer),
      .cfg_bdtr     (cfg_bdtr),
      .cfg_cr1      (cfg_cr1),
      .rearm_en     (rearm_en),
      .rearm_delay  (rearm_delay),
      .timx_int_bk  (timx_int_bk),
      .timx_psel    (timx_psel),
      .timx_penable (timx_penable),
      .timx_pwrite  (timx_pwrite),
      .timx_paddr   (timx_paddr),
      .timx_pwdata  (timx_pwdata),
      .timx_prdata  (timx_prdata),
      .timx_pready  (timx_pready),
      .busy         (busy),
      .done         (done),
      .error        (error),
      .rearm_cnt    (rearm_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Slave answers in the ACCESS phase; completed transfers are popped from the scoreboard.
   always @(negedge clk) begin
      if (timx_psel && timx_penable) begin
         slv_rdy = !(timx_paddr == stall_addr || (timx_paddr == ws_addr && acc_cnt < ws_n));
         timx_pready = slv_rdy;
         timx_prdata = (ov_en && timx_paddr == 16'h0044) ? ov_val : regs[timx_paddr[7:2]];
         if (slv_rdy) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $error("FAIL unexpected_xfer: observed addr %h expected no transfer", timx_paddr);
            end else begin
               slv_e = exp_q.pop_front();
               check("xfer_addr", {16'h0, timx_paddr}, {16'h0, slv_e.addr});
               check("xfer_dir", {31'h0, timx_pwrite}, {31'h0, slv_e.write});
               if (slv_e.write) check("xfer_wdata", timx_pwdata, slv_e.data);
            end
            if (timx_pwrite) regs[timx_paddr[7:2]] = timx_pwdata;
            acc_cnt = 0;
         end else begin
            acc_cnt++;
         end
      end else begin
         timx_pready = 1'b0;
         acc_cnt = 0;
      end
   end

   task automatic push_prog(input int n);
      xfer_t t[9];
      t[0] = '{16'h002C, 1'b1, {16'h0, cfg_arr}};
      t[1] = '{16'h0034, 1'b1, {16'h0, cfg_ccr1}};
      t[2] = '{16'h000C, 1'b1, {16'h0, cfg_dier}};
      t[3] = '{16'h0018, 1'b1, {16'h0, cfg_ccmr1}};
      t[4] = '{16'h0014, 1'b1, 32'h0000_0001};
      t[5] = '{16'h0020, 1'b1, {16'h0, cfg_ccer}};
      t[6] = '{16'h0044, 1'b1, {16'h0, cfg_bdtr}};
      t[7] = '{16'h0000, 1'b1, {16'h0, cfg_cr1}};
      t[8] = '{16'h0044, 1'b0, 32'h0};
      for (int i = 0; i < n; i++) exp_q.push_back(t[i]);
   endtask

   task automatic run_prog(output int dcyc, output logic dn_o, output logic er_o,
                           output logic b1_o, output logic bz_o);
      @(negedge clk);
      start = 1'b1;
      t0 = cyc;
      @(negedge clk);
      start = 1'b0;
      b1_o = busy;
      dn_o = 1'b0;
      er_o = 1'b0;
      bz_o = 1'b1;
      dcyc = -1;
      for (int i = 0; i < 200 && dcyc < 0; i++) begin
         if (done || error) begin
            dn_o = done;
            er_o = error;
            bz_o = busy;
            dcyc = cyc - t0;
         end else begin
            @(negedge clk);
         end
      end
   endtask

   task automatic wait_psel(input int budget, output int c);
      c = -1;
      for (int i = 1; i <= budget && c < 0; i++) begin
         @(negedge clk);
         if (i == 2) timx_int_bk = 1'b0;
         if (i == 50) timx_int_bk = 1'b1;
         if (timx_psel) c = cyc - t0;
      end
   endtask

   initial begin
      cfg_arr = 16'd8; cfg_ccr1 = 16'd4; cfg_dier = 16'd3; cfg_ccmr1 = 16'h0068;
      cfg_ccer = 16'd5; cfg_bdtr = 16'hBC00; cfg_cr1 = 16'h00A1;
      for (int i = 0; i < 64; i++) regs[i] = 32'h0;

      repeat (3) @(negedge clk);
      check("rst_ctrl", {29'h0, timx_psel, timx_penable, timx_pwrite}, 32'h0);
      check("rst_addr", {16'h0, timx_paddr}, 32'h0);
      check("rst_wdata", timx_pwdata, 32'h0);
      check("rst_status", {21'h0, busy, done, error, rearm_cnt}, 32'h0);
      apb_rst = 1'b0;

      push_prog(9);
      run_prog(dc, dn, er, b1, bz);
      check("t1_done_cycle", dc, 19);
      check("t1_done", {31'h0, dn}, 32'h1);
      check("t1_error", {31'h0, er}, 32'h0);
      check("t1_busy_c1", {31'h0, b1}, 32'h1);
      check("t1_busy_at_done", {31'h0, bz}, 32'h0);
      check("t1_sb_empty", exp_q.size(), 0);

      ws_addr = 16'h0020; ws_n = 3;
      push_prog(9);
      run_prog(dc, dn, er, b1, bz);
      check("t2_done_cycle", dc, 22);
      check("t2_done", {31'h0, dn}, 32'h1);
      ws_addr = 16'hFFFF;

      stall_addr = 16'h000C;
      push_prog(2);
      run_prog(dc, dn, er, b1, bz);
      check("t3_err_cycle", dc, 22);
      check("t3_error", {31'h0, er}, 32'h1);
      check("t3_psel", {31'h0, timx_psel}, 32'h0);
      check("t3_busy", {31'h0, bz}, 32'h0);
      check("t3_sb_empty", exp_q.size(), 0);
      stall_addr = 16'hFFFF;

      ov_en = 1'b1; ov_val = 32'h0000_3C00;
      push_prog(9);
      run_prog(dc, dn, er, b1, bz);
      check("t4_moe_masked_done", {31'h0, dn}, 32'h1);
      check("t4_moe_masked_err", {31'h0, er}, 32'h0);
      check("t4_done_cycle", dc, 19);

      ov_val = 32'h0000_BD00;
      push_prog(9);
      run_prog(dc, dn, er, b1, bz);
      check("t4_mismatch_err", {31'h0, er}, 32'h1);
      check("t4_mismatch_done", {31'h0, dn}, 32'h0);
      check("t4_mismatch_cycle", dc, 19);
      ov_en = 1'b0;

      push_prog(9);
      run_prog(dc, dn, er, b1, bz);
      check("t5_prog_done", {31'h0, dn}, 32'h1);

      rearm_en = 1'b0;
      @(negedge clk);
      timx_int_bk = 1'b1;
      t0 = cyc;
      wait_psel(40, rise);
      check("t5_rearm_disabled", rise, -1);
      timx_int_bk = 1'b0;

      rearm_en = 1'b1; rearm_delay = 16'd100;
      exp_q.push_back('{16'h0044, 1'b1, 32'h0000_BC00});
      @(negedge clk);
      timx_int_bk = 1'b1;
      t0 = cyc;
      wait_psel(300, rise);
      check("t5_rearm_setup_cycle", rise, 102);
      repeat (3) @(negedge clk);
      check("t5_rearm_cnt", {24'h0, rearm_cnt}, 32'h1);
      check("t5_sb_empty", exp_q.size(), 0);
      npsel = 0;
      repeat (150) begin
         @(negedge clk);
         if (timx_psel) npsel++;
      end
      check("t5_second_edge_ignored", npsel, 0);
      timx_int_bk = 1'b0;

      rearm_delay = 16'd0;
      exp_q.push_back('{16'h0044, 1'b1, 32'h0000_BC00});
      @(negedge clk);
      timx_int_bk = 1'b1;
      t0 = cyc;
      wait_psel(20, rise);
      check("t5_delay0_setup_cycle", rise, 2);
      repeat (3) @(negedge clk);
      check("t5_delay0_cnt", {24'h0, rearm_cnt}, 32'h2);
      timx_int_bk = 1'b0;

      ws_addr = 16'h0014; ws_n = 5;
      push_prog(4);
      @(negedge clk);
      start = 1'b1;
      t0 = cyc;
      @(negedge clk);
      start = 1'b0;
      check("t6_rearm_cnt_cleared", {24'h0, rearm_cnt}, 32'h0);
      while (cyc - t0 < 10) @(negedge clk);
      check("t6_step4_access", {14'h0, timx_psel, timx_penable, timx_paddr}, {14'h0, 2'b11, 16'h0014});
      apb_rst = 1'b1;
      @(negedge clk);
      check("t6_rst_ctrl", {29'h0, timx_psel, timx_penable, timx_pwrite}, 32'h0);
      check("t6_rst_bus", {timx_paddr, 16'h0} | timx_pwdata, 32'h0);
      check("t6_rst_status", {21'h0, busy, done, error, rearm_cnt}, 32'h0);
      apb_rst = 1'b0;
      ws_addr = 16'hFFFF;
      check("t6_sb_empty", exp_q.size(), 0);
      push_prog(9);
      run_prog(dc, dn, er, b1, bz);
      check("t6_restart_cycle", dc, 19);
      check("t6_restart_done", {31'h0, dn}, 32'h1);
      check("t6_sb_empty_end", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
